vid_sync_monitor: RTL

VID_SYNC_MONITOR -- requirements
Module: vid_sync_monitor

---
 rtl/vid_sync_monitor.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vid_sync_monitor.sv
// Video sync timing monitor: measures hsync/vsync/vde timing from the HDMI receive
// path and reports lock once LOCK_FRAMES consecutive frames match the expected raster.
module vid_sync_monitor #(
    parameter int H_ACTIVE      = -1,
    parameter int H_FRONT_PORCH = -1,
    parameter int H_SYNC_WIDTH  = -1,
    parameter int H_BACK_PORCH  = -1,
    parameter int V_ACTIVE      = -1,
    parameter int V_FRONT_PORCH = -1,
    parameter int V_SYNC_WIDTH  = -1,
    parameter int V_BACK_PORCH  = -1,
    parameter int LOCK_FRAMES   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_vde,
    output logic        locked,
    output logic        lost_lock,
    output logic [15:0] meas_h_total,
    output logic [15:0] meas_h_active,
    output logic [15:0] meas_v_total,
    output logic [15:0] meas_v_active
);

    localparam int H_FRAME = H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_FRAME = V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [15:0] H_FRAME_C  = 16'(H_FRAME);
    localparam logic [15:0] H_ACTIVE_C = 16'(H_ACTIVE);
    localparam logic [15:0] V_FRAME_C  = 16'(V_FRAME);
    localparam logic [15:0] V_ACTIVE_C = 16'(V_ACTIVE);
    localparam logic [15:0] WD_LIMIT   = 16'(2 * H_FRAME);
    localparam logic [15:0] LOCK_C     = 16'(LOCK_FRAMES);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        hsync_p0, vsync_p0, vde_p0;
    logic        hsync_p1, vsync_p1;
    logic        hrise, vrise;

    logic [15:0] pix_cnt_p1, act_cnt_p1, line_cnt_p1, act_line_cnt_p1;
    logic [15:0] last_len_p1, last_act_p1;
    logic        frame_bad_p1;

    logic [1:0]  state, state_nxt;
    logic [15:0] good_cnt, good_nxt, good_inc;
    logic        drop;

    logic        line_bad, bad_eff, frame_good, wd_fire;
    logic [15:0] line_eff, act_line_eff, len_eff, act_eff;

    // Stage p0: input register; stage p1: previous sample for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p0 <= 1'b0;
            vsync_p0 <= 1'b0;
            vde_p0   <= 1'b0;
            hsync_p1 <= 1'b0;
            vsync_p1 <= 1'b0;
        end else begin
            hsync_p0 <= in_hsync;
            vsync_p0 <= in_vsync;
            vde_p0   <= in_vde;
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
        end
    end

    assign hrise = hsync_p0 & ~hsync_p1;
    assign vrise = vsync_p0 & ~vsync_p1;

    // A coinciding hsync rise closes its line into the frame before vsync closes the frame
    always_comb begin
        line_bad     = 1'b0;
        line_eff     = line_cnt_p1;
        act_line_eff = act_line_cnt_p1;
        len_eff      = last_len_p1;
        act_eff      = last_act_p1;
        if (hrise) begin
            line_bad = (pix_cnt_p1 != H_FRAME_C) ||
                       ((act_cnt_p1 != 16'd0) && (act_cnt_p1 != H_ACTIVE_C));
            line_eff = sat_inc(line_cnt_p1);
            len_eff  = pix_cnt_p1;
            if (act_cnt_p1 != 16'd0) begin
                act_line_eff = sat_inc(act_line_cnt_p1);
                act_eff      = act_cnt_p1;
            end
        end
        bad_eff    = frame_bad_p1 | line_bad;
        frame_good = !bad_eff && (line_eff == V_FRAME_C) && (act_line_eff == V_ACTIVE_C);
        wd_fire    = !hrise && (pix_cnt_p1 >= WD_LIMIT);
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        good_inc  = sat_inc(good_cnt);
        drop      = 1'b0;
        if (wd_fire) begin
            state_nxt = SEARCH;
            good_nxt  = 16'd0;
            drop      = (state == LOCKED);
        end else if (vrise) begin
            case (state)
                SEARCH: begin
                    state_nxt = VERIFY;
                    good_nxt  = 16'd0;
                end
                VERIFY: begin
                    if (frame_good) begin
                        good_nxt = good_inc;
                        if (good_inc >= LOCK_C)
                            state_nxt = LOCKED;
                    end else begin
                        good_nxt = 16'd0;
                    end
                end
                LOCKED: begin
                    if (!frame_good) begin
                        state_nxt = SEARCH;
                        good_nxt  = 16'd0;
                        drop      = 1'b1;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    good_nxt  = 16'd0;
                end
            endcase
        end
    end

    // Stage p2: line/frame counters, lock state and measurement outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_p1      <= 16'd0;
            act_cnt_p1      <= 16'd0;
            line_cnt_p1     <= 16'd0;
            act_line_cnt_p1 <= 16'd0;
            frame_bad_p1    <= 1'b0;
            last_len_p1     <= 16'd0;
            last_act_p1     <= 16'd0;
        end else if (wd_fire) begin
            pix_cnt_p1      <= 16'd0;
            act_cnt_p1      <= 16'd0;
            line_cnt_p1     <= 16'd0;
            act_line_cnt_p1 <= 16'd0;
            frame_bad_p1    <= 1'b0;
        end else begin
            pix_cnt_p1  <= hrise ? 16'd1 : sat_inc(pix_cnt_p1);
            last_len_p1 <= len_eff;
            last_act_p1 <= act_eff;
            if (hrise)
                act_cnt_p1 <= {15'd0, vde_p0};
            else if (vde_p0)
                act_cnt_p1 <= sat_inc(act_cnt_p1);
            if (vrise) begin
                line_cnt_p1     <= 16'd0;
                act_line_cnt_p1 <= 16'd0;
                frame_bad_p1    <= 1'b0;
            end else begin
                line_cnt_p1     <= line_eff;
                act_line_cnt_p1 <= act_line_eff;
                frame_bad_p1    <= bad_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SEARCH;
            good_cnt      <= 16'd0;
            locked        <= 1'b0;
            lost_lock     <= 1'b0;
            meas_h_total  <= 16'd0;
            meas_h_active <= 16'd0;
            meas_v_total  <= 16'd0;
            meas_v_active <= 16'd0;
        end else begin
            state     <= state_nxt;
            good_cnt  <= good_nxt;
            locked    <= (state_nxt == LOCKED);
            lost_lock <= drop;
            if (vrise) begin
                meas_h_total  <= len_eff;
                meas_h_active <= act_eff;
                meas_v_total  <= line_eff;
                meas_v_active <= act_line_eff;
            end
        end
    end

endmodule
